// File: rtl/ctrl_pkg.sv
// Shared types for the ID-stage control pipeline: opcode map, ALU/ri encodings,
// and the per-stage control bundles, whose all-zero value is a bubble.
package ctrl_pkg;

    localparam int OP_W    = 4;
    localparam int REG_AW  = 4;
    localparam int ALUOP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SUB  = 4'h0, OP_ADD = 4'h1, OP_LSL = 4'h2, OP_NEG = 4'h3,
        OP_BEQ  = 4'h4, OP_BGT = 4'h5, OP_BLT = 4'h6, OP_B   = 4'h7,
        OP_MOVI = 4'h8, OP_LDR = 4'h9, OP_STR = 4'hA, OP_CMP = 4'hB,
        OP_MOVR = 4'hC
    } opcode_e;

    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_LSL = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_NEG = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_MEM = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_CMP = 3'b101;

    localparam logic [1:0] RI_UNARY = 2'b00;
    localparam logic [1:0] RI_RR    = 2'b01;
    localparam logic [1:0] RI_IMM   = 2'b10;
    localparam logic [1:0] RI_SH_BR = 2'b11;

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         ri;
        logic               alu_mux;
        logic               alu_mux1;
        logic               branch;
        logic [1:0]         br_type;
        logic [REG_AW-1:0]  rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic              valid;
        logic              wme;
        logic              mm;
        logic              am;
        logic              wm;
        logic              is_load;
        logic [REG_AW-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic              valid;
        logic              wre;
        logic              wbs;
        logic              rde;
        logic [REG_AW-1:0] rd;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: ID instruction -> EX/MEM/WB control bundles
// plus source-register usage; invalid or unassigned opcodes yield bubbles.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic              valid,
    input  logic [OP_W-1:0]   opcode,
    input  logic [REG_AW-1:0] rd,
    output ex_ctrl_t          ex,
    output mem_ctrl_t         mem,
    output wb_ctrl_t          wb,
    output logic              rs1_used,
    output logic              rs2_used,
    output logic              illegal
);

    logic assigned;

    always_comb begin
        ex          = EX_BUBBLE;
        mem         = MEM_BUBBLE;
        wb          = WB_BUBBLE;
        assigned    = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;
        ex.valid    = 1'b1;
        ex.alu_mux1 = 1'b1;
        ex.rd       = rd;
        mem.valid   = 1'b1;
        mem.rd      = rd;
        wb.valid    = 1'b1;
        wb.wre      = 1'b1;
        wb.wbs      = 1'b1;
        wb.rd       = rd;
        case (opcode_e'(opcode))
            OP_SUB: begin ex.aluop = ALU_SUB; ex.ri = RI_RR; rs2_used = 1'b1; end
            OP_ADD: begin ex.aluop = ALU_ADD; ex.ri = RI_RR; rs2_used = 1'b1; end
            OP_LSL: begin ex.aluop = ALU_LSL; ex.ri = RI_SH_BR; end
            OP_NEG, OP_MOVR: begin ex.aluop = ALU_NEG; ex.ri = RI_UNARY; end
            OP_BEQ, OP_BGT, OP_BLT, OP_B: begin
                ex.ri      = RI_SH_BR;
                ex.branch  = 1'b1;
                ex.br_type = opcode[1:0];
                wb.wre     = 1'b0;
                rs1_used   = (opcode_e'(opcode) != OP_B);
            end
            OP_MOVI: begin ex.ri = RI_IMM; mem.am = 1'b1; rs1_used = 1'b0; end
            OP_LDR: begin
                ex.aluop    = ALU_MEM;
                ex.ri       = RI_IMM;
                mem.wm      = 1'b1;
                mem.is_load = 1'b1;
                wb.wbs      = 1'b0;
            end
            OP_STR: begin
                ex.aluop = ALU_MEM;
                ex.ri    = RI_IMM;
                mem.wme  = 1'b1;
                mem.am   = 1'b1;
                wb.rde   = 1'b1;
                rs2_used = 1'b1;
            end
            OP_CMP: begin ex.aluop = ALU_CMP; ex.ri = RI_UNARY; rs2_used = 1'b1; end
            default: assigned = 1'b0;
        endcase
        illegal = valid & ~assigned;
        if (!(valid && assigned)) begin
            ex       = EX_BUBBLE;
            mem      = MEM_BUBBLE;
            wb       = WB_BUBBLE;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end

endmodule

// File: rtl/control_pipeline_unit.sv
// ID-stage control pipeline: decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use hazard, flush and external stall. CTRL_ILLEGAL_TRAP_EN adds a sticky illegal-opcode flag.
module control_pipeline_unit
    import ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_opcode,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_flush,
    input  logic               stall_ext,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [1:0]         ex_ri,
    output logic               ex_alu_mux,
    output logic               ex_alu_mux1,
    output logic               ex_branch,
    output logic [1:0]         ex_br_type,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               mem_valid,
    output logic               mem_wme,
    output logic               mem_mm,
    output logic               mem_am,
    output logic               mem_wm,
    output logic               mem_is_load,
    output logic [REG_AW-1:0]  mem_rd,
    output logic               wb_valid,
    output logic               wb_wre,
    output logic               wb_wbs,
    output logic               wb_rde,
    output logic [REG_AW-1:0]  wb_rd
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    input  logic               illegal_clr,
    output logic               illegal_op
`endif
);

    ex_ctrl_t  dec_ex,  ex_q;
    mem_ctrl_t dec_mem, ex_mem_q, mem_q;
    wb_ctrl_t  dec_wb,  ex_wb_q,  mem_wb_q, wb_q;
    logic      rs1_used, rs2_used, dec_illegal, load_use;

    ctrl_decode u_dec (
        .valid    (id_valid),
        .opcode   (id_opcode),
        .rd       (id_rd),
        .ex       (dec_ex),
        .mem      (dec_mem),
        .wb       (dec_wb),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .illegal  (dec_illegal)
    );

    assign load_use = id_valid & ex_q.valid & ex_mem_q.is_load &
                      ((rs1_used & (id_rs1 == ex_q.rd)) | (rs2_used & (id_rs2 == ex_q.rd)));
    // PC is already frozen by stall_ext, and a flush discards the ID instruction anyway.
    assign hazard_stall = load_use & ~stall_ext & ~ex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= EX_BUBBLE;
            ex_mem_q <= MEM_BUBBLE;
            ex_wb_q  <= WB_BUBBLE;
            mem_q    <= MEM_BUBBLE;
            mem_wb_q <= WB_BUBBLE;
            wb_q     <= WB_BUBBLE;
        end else if (!stall_ext) begin
            mem_q    <= ex_mem_q;
            mem_wb_q <= ex_wb_q;
            wb_q     <= mem_wb_q;
            if (ex_flush || load_use) begin
                ex_q     <= EX_BUBBLE;
                ex_mem_q <= MEM_BUBBLE;
                ex_wb_q  <= WB_BUBBLE;
            end else begin
                ex_q     <= dec_ex;
                ex_mem_q <= dec_mem;
                ex_wb_q  <= dec_wb;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)                                       illegal_op <= 1'b0;
        else if (dec_illegal && !stall_ext && !ex_flush) illegal_op <= 1'b1;
        else if (illegal_clr)                          illegal_op <= 1'b0;
    end
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    assign ex_valid    = ex_q.valid;
    assign ex_aluop    = ex_q.aluop;
    assign ex_ri       = ex_q.ri;
    assign ex_alu_mux  = ex_q.alu_mux;
    assign ex_alu_mux1 = ex_q.alu_mux1;
    assign ex_branch   = ex_q.branch;
    assign ex_br_type  = ex_q.br_type;
    assign ex_rd       = ex_q.rd;
    assign mem_valid   = mem_q.valid;
    assign mem_wme     = mem_q.wme;
    assign mem_mm      = mem_q.mm;
    assign mem_am      = mem_q.am;
    assign mem_wm      = mem_q.wm;
    assign mem_is_load = mem_q.is_load;
    assign mem_rd      = mem_q.rd;
    assign wb_valid    = wb_q.valid;
    assign wb_wre      = wb_q.wre;
    assign wb_wbs      = wb_q.wbs;
    assign wb_rde      = wb_q.rde;
    assign wb_rd       = wb_q.rd;

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Directed bench for control_pipeline_unit: per-opcode decode table plus
// hazard, flush, external stall, reset and (with CTRL_ILLEGAL_TRAP_EN) trap sequences.
module tb_control_pipeline_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, ex_flush, stall_ext;
    logic [3:0] id_opcode, id_rs1, id_rs2, id_rd;
    logic       hazard_stall;
    logic       ex_valid, ex_alu_mux, ex_alu_mux1, ex_branch;
    logic [2:0] ex_aluop;
    logic [1:0] ex_ri, ex_br_type;
    logic [3:0] ex_rd, mem_rd, wb_rd;
    logic       mem_valid, mem_wme, mem_mm, mem_am, mem_wm, mem_is_load;
    logic       wb_valid, wb_wre, wb_wbs, wb_rde;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_clr, illegal_op;
`endif

    always #5 clk = ~clk;

    control_pipeline_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_flush(ex_flush), .stall_ext(stall_ext), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_ri(ex_ri),
        .ex_alu_mux(ex_alu_mux), .ex_alu_mux1(ex_alu_mux1), .ex_branch(ex_branch),
        .ex_br_type(ex_br_type), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_wme(mem_wme), .mem_mm(mem_mm), .mem_am(mem_am),
        .mem_wm(mem_wm), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_wre(wb_wre), .wb_wbs(wb_wbs), .wb_rde(wb_rde), .wb_rd(wb_rd)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal_clr(illegal_clr), .illegal_op(illegal_op)
`endif
    );

    // {valid, aluop, ri, alu_mux, alu_mux1, branch, br_type, rd}
    logic [14:0] ex_vec;
    // {valid, wme, mm, am, wm, is_load, rd}
    logic [9:0]  mem_vec;
    // {valid, wre, wbs, rde, rd}
    logic [7:0]  wb_vec;
    assign ex_vec  = {ex_valid, ex_aluop, ex_ri, ex_alu_mux, ex_alu_mux1, ex_branch, ex_br_type, ex_rd};
    assign mem_vec = {mem_valid, mem_wme, mem_mm, mem_am, mem_wm, mem_is_load, mem_rd};
    assign wb_vec  = {wb_valid, wb_wre, wb_wbs, wb_rde, wb_rd};

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [14:0] ex;
        logic [9:0]  mem;
        logic [7:0]  wb;
    } vec_t;

    vec_t tbl[15];
    int   errs   = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] rd);
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 4'h1, 15'b1_000_01_0_1_0_00_0001, 10'b1_00000_0001, 8'b1110_0001};
        tbl[1]  = '{1'b1, 4'h1, 4'h3, 15'b1_001_01_0_1_0_00_0011, 10'b1_00000_0011, 8'b1110_0011};
        tbl[2]  = '{1'b1, 4'h2, 4'h2, 15'b1_010_11_0_1_0_00_0010, 10'b1_00000_0010, 8'b1110_0010};
        tbl[3]  = '{1'b1, 4'h3, 4'h4, 15'b1_011_00_0_1_0_00_0100, 10'b1_00000_0100, 8'b1110_0100};
        tbl[4]  = '{1'b1, 4'h4, 4'h6, 15'b1_000_11_0_1_1_00_0110, 10'b1_00000_0110, 8'b1010_0110};
        tbl[5]  = '{1'b1, 4'h5, 4'h7, 15'b1_000_11_0_1_1_01_0111, 10'b1_00000_0111, 8'b1010_0111};
        tbl[6]  = '{1'b1, 4'h6, 4'h8, 15'b1_000_11_0_1_1_10_1000, 10'b1_00000_1000, 8'b1010_1000};
        tbl[7]  = '{1'b1, 4'h7, 4'h9, 15'b1_000_11_0_1_1_11_1001, 10'b1_00000_1001, 8'b1010_1001};
        tbl[8]  = '{1'b1, 4'h8, 4'h5, 15'b1_000_10_0_1_0_00_0101, 10'b1_00100_0101, 8'b1110_0101};
        tbl[9]  = '{1'b1, 4'h9, 4'h5, 15'b1_100_10_0_1_0_00_0101, 10'b1_00011_0101, 8'b1100_0101};
        tbl[10] = '{1'b1, 4'hA, 4'hA, 15'b1_100_10_0_1_0_00_1010, 10'b1_10100_1010, 8'b1111_1010};
        tbl[11] = '{1'b1, 4'hB, 4'hB, 15'b1_101_00_0_1_0_00_1011, 10'b1_00000_1011, 8'b1110_1011};
        tbl[12] = '{1'b1, 4'hC, 4'hC, 15'b1_011_00_0_1_0_00_1100, 10'b1_00000_1100, 8'b1110_1100};
        tbl[13] = '{1'b1, 4'hE, 4'hF, 15'd0, 10'd0, 8'd0};
        tbl[14] = '{1'b0, 4'h1, 4'h3, 15'd0, 10'd0, 8'd0};

        rst = 1'b1; ex_flush = 1'b0; stall_ext = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_clr = 1'b0;
`endif
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step; step;
        chk("reset_ex", ex_vec, 15'd0);
        chk("reset_mem", mem_vec, 10'd0);
        chk("reset_wb", wb_vec, 8'd0);
        chk("reset_hazard", hazard_stall, 1'b0);
        rst = 1'b0;

        // Each opcode travels alone through EX, MEM, WB.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].op, 4'h0, 4'h0, tbl[i].rd);
            step;
            chk($sformatf("tbl%0d_ex", i), ex_vec, tbl[i].ex);
            drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
            step;
            chk($sformatf("tbl%0d_mem", i), mem_vec, tbl[i].mem);
            step;
            chk($sformatf("tbl%0d_wb", i), wb_vec, tbl[i].wb);
        end

        // ldr r5 then sub using r5: one bubble, then sub proceeds.
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h5);
        step;
        drive(1'b1, 4'h0, 4'h5, 4'h0, 4'h6);
        #1 chk("lu_stall", hazard_stall, 1'b1);
        step;
        chk("lu_ex_bubble", ex_valid, 1'b0);
        chk("lu_mem_load", mem_is_load, 1'b1);
        chk("lu_stall_once", hazard_stall, 1'b0);
        step;
        chk("lu_sub_ex", ex_vec, 15'b1_000_01_0_1_0_00_0110);
        chk("lu_ldr_wb", wb_vec, 8'b1100_0101);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step;

        // ldr r5 then movi r5: rs1 unused, no stall.
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h5);
        step;
        drive(1'b1, 4'h8, 4'h5, 4'h5, 4'h5);
        #1 chk("movi_nostall", hazard_stall, 1'b0);
        step;
        chk("movi_ex", ex_vec, 15'b1_000_10_0_1_0_00_0101);

        // ldr r5 then str reading r5 as rs2: stalls.
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h5);
        step;
        drive(1'b1, 4'hA, 4'h0, 4'h5, 4'h7);
        #1 chk("rs2_stall", hazard_stall, 1'b1);
        step; step;
        chk("rs2_str_ex", ex_vec, 15'b1_100_10_0_1_0_00_0111);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step; step; step;

        // beq in EX, flush with str in ID.
        drive(1'b1, 4'h4, 4'h1, 4'h2, 4'h0);
        step;
        drive(1'b1, 4'hA, 4'h1, 4'h2, 4'h3);
        ex_flush = 1'b1;
        step;
        ex_flush = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("fl_ex_bubble", ex_valid, 1'b0);
        chk("fl_beq_mem", mem_vec, 10'b1_00000_0000);
        step;
        chk("fl_wme0", mem_wme, 1'b0);
        chk("fl_beq_wb", wb_vec, 8'b1010_0000);
        step;
        chk("fl_wme1", mem_wme, 1'b0);

        // Flush and load-use hazard together: flush wins, no stall.
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h5);
        step;
        drive(1'b1, 4'h0, 4'h5, 4'h0, 4'h6);
        ex_flush = 1'b1;
        #1 chk("flhz_nostall", hazard_stall, 1'b0);
        step;
        ex_flush = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("flhz_ex_bubble", ex_valid, 1'b0);
        step; step;

        // add, sub, ldr in flight, then 3 cycles of stall_ext with a hazard pending in ID.
        drive(1'b1, 4'h1, 4'h0, 4'h0, 4'h3); step;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h1); step;
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h5); step;
        drive(1'b1, 4'h0, 4'h5, 4'h0, 4'h6);
        stall_ext = 1'b1;
        #1 chk("se_nostall", hazard_stall, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step;
            chk($sformatf("se%0d_ex", c), ex_vec, 15'b1_100_10_0_1_0_00_0101);
            chk($sformatf("se%0d_mem", c), mem_vec, 10'b1_00000_0001);
            chk($sformatf("se%0d_wb", c), wb_vec, 8'b1110_0011);
        end
        stall_ext = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step;
        chk("se_resume_ex", ex_vec, 15'd0);
        chk("se_resume_mem", mem_vec, 10'b1_00011_0101);
        chk("se_resume_wb", wb_vec, 8'b1110_0001);
        step; step;

`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_clr = 1'b1; step; illegal_clr = 1'b0;
        chk("trap_clear0", illegal_op, 1'b0);
        drive(1'b1, 4'hE, 4'h0, 4'h0, 4'h2);
        step;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("trap_set", illegal_op, 1'b1);
        chk("trap_bubble", ex_vec, 15'd0);
        step;
        chk("trap_sticky", illegal_op, 1'b1);
        illegal_clr = 1'b1; step; illegal_clr = 1'b0;
        chk("trap_clr", illegal_op, 1'b0);
`endif

        // Reset with three instructions in flight.
        drive(1'b1, 4'h1, 4'h0, 4'h0, 4'h3); step;
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h1); step;
        drive(1'b1, 4'h9, 4'h0, 4'h0, 4'h5); step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_fly_ex", ex_vec, 15'd0);
        chk("rst_fly_mem", mem_vec, 10'd0);
        chk("rst_fly_wb", wb_vec, 8'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/control_pipeline_unit.md
Name: control_pipeline_unit

Overview:
- Pipelined successor of the combinational opcode decoder, sitting in the ID stage of the pipelined CPU.
- Decodes the current ID instruction into a control bundle and registers it into the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and handles branch flush and external stall.
- The datapath takes each stage's control signals directly from this block.

Parameters:
- OP_W, 4: opcode width; opcodes at or above 2^4 decode as unassigned.
- REG_AW, 4: register-address width for rs1/rs2/rd.
- ALUOP_W, 3: ALU operation code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OP_W  ID opcode
- id_rs1  in  REG_AW  source register 1
- id_rs2  in  REG_AW  source register 2
- id_rd  in  REG_AW  destination register
- ex_flush  in  1  branch taken, resolved in EX; kills the ID instruction
- stall_ext  in  1  memory stall; freezes all control registers
- hazard_stall  out  1  hold PC and IF/ID (combinational)
- ex_valid, ex_aluop[ALUOP_W], ex_ri[2], ex_alu_mux, ex_alu_mux1, ex_branch, ex_br_type[2], ex_rd[REG_AW]  out  EX bundle
- mem_valid, mem_wme, mem_mm, mem_am, mem_wm, mem_is_load, mem_rd[REG_AW]  out  MEM bundle
- wb_valid, wb_wre, wb_wbs, wb_rde, wb_rd[REG_AW]  out  WB bundle

Behaviour:
- Synchronous active-high reset: every output register clears to 0. A bubble is the all-zero bundle.
- Decode is combinational on the ID inputs. Don't-care values are replaced by 0, so no X is ever registered.
- Opcode map: 0 sub, 1 add, 2 lsl, 3 neg, 4 beq, 5 bgt, 6 blt, 7 b, 8 movi, 9 ldr, A str, B cmp, C movr; D–F unassigned.
- ALU ops and ri source:
  - sub 000, add 001, lsl 010, neg/movr 011, ldr/str 100, cmp 101; branches and movi 000.
  - ri: sub/add 01; lsl/branches 11; movi/ldr/str 10; neg/cmp/movr 00.
- Register-file and writeback controls:
  - wre=1 for sub, add, lsl, neg, movi, ldr, str, cmp, movr; wre=0 for branches.
  - wbs=0 only for ldr; otherwise 1.
  - wm=1 only for ldr.
  - rde=1 only for str.
- Memory and mux controls:
  - wme=1 only for str.
  - am=1 for movi and str.
  - mm=0 for all opcodes.
  - alu_mux=0, alu_mux1=1 for every assigned opcode.
- Branch fields:
  - ex_branch=1 for opcodes 4–7.
  - ex_br_type = opcode[1:0]: 00 beq, 01 bgt, 10 blt, 11 b.
- Unassigned opcodes, or id_valid=0, produce a bubble.
- Register usage:
  - rs1 used by every assigned opcode except movi and b.
  - rs2 used by sub, add, cmp, str.
- Latency: the ID decode appears on the EX bundle 1 cycle later, MEM after 2 cycles, WB after 3.
- Load-use hazard:
  - Condition: hazard_stall = id_valid & ex_valid & EX is ldr & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)).
  - Response: EX captures a bubble; MEM and WB advance normally; stall lasts exactly 1 cycle per hazard.
- Priority per edge: rst > stall_ext > ex_flush > hazard > normal advance.
  - stall_ext=1: all three stage registers hold. hazard_stall is forced to 0, since the PC is already frozen externally.
  - ex_flush=1: EX captures a bubble, overriding hazard. MEM captures the current EX, i.e. the branch itself, which completes.
- Flush and hazard in the same cycle: flush wins; hazard_stall=0.
- Reset mid-operation: all in-flight bundles are discarded on the same edge.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_op (1) and input illegal_clr (1).
  - illegal_op is a sticky flag, set the cycle after a valid, unstalled, unflushed ID instruction has an unassigned opcode.
  - illegal_op is cleared by illegal_clr or rst; set wins over a simultaneous clear.
  - The offending instruction still becomes a bubble.
- Undefined: no illegal_op or illegal_clr ports; unassigned opcodes are silently bubbled.

Decomposition:
- Package ctrl_pkg holds:
  - opcode enum (OP_W wide);
  - ALUOP localparams;
  - ri encodings;
  - packed structs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t;
  - bubble constants for each struct.
- Sub-module ctrl_decode: purely combinational opcode-to-{ex,mem,wb} struct, plus rs1_used/rs2_used flags.
- Top level holds the stage registers, the hazard logic and the optional trap.

Test Plan:
- Reset, then add (op 1, rd=3) with id_valid=1 → next cycle ex_aluop=001, ex_ri=01, ex_rd=3; two cycles later wb_wre=1, wb_wbs=1, wb_rd=3.
- ldr rd=5, then sub rs1=5 → hazard_stall=1 for 1 cycle, EX shows a bubble (ex_valid=0), sub reaches EX one cycle later; wb_wbs=0 for the ldr.
- ldr rd=5, then movi rd=5 (rs1 unused) → no stall.
- beq in EX with ex_flush=1 and str in ID → EX captures a bubble, mem_wme never pulses; the beq appears in MEM with mem_valid=1.
- stall_ext=1 for 3 cycles mid-stream → all bundles hold their values; hazard_stall=0; the pipeline resumes unchanged.
- Opcode E with id_valid=1 → all-zero bundle; with CTRL_ILLEGAL_TRAP_EN, illegal_op=1 the next cycle until illegal_clr.
- rst asserted while three instructions are in flight → all outputs 0 the next cycle.
